// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin arbiter sharing one synchronous sprite ROM
// port between two render requesters, with tagged fixed-latency responses.
module sprite_rom_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_data
);

    logic              prio_q, prio_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]  tag_vld_q, tag_vld_d;
    logic [ROM_LAT:0]  tag_id_q, tag_id_d;
    logic              rsp_valid0_q, rsp_valid0_d;
    logic              rsp_valid1_q, rsp_valid1_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              tag_out_vld;
    logic              tag_out_id;

    // Grant decode: a sole requester wins, a tie goes to the prio holder, nothing during reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!Reset) begin
            gnt0 = req0 && (!req1 || !prio_q);
            gnt1 = req1 && (!req0 ||  prio_q);
        end
    end

    assign tag_out_vld = tag_vld_q[ROM_LAT];
    assign tag_out_id  = tag_id_q[ROM_LAT];

    // Next state: priority flip, ROM address capture, tag shift and response capture
    always_comb begin
        prio_d       = prio_q;
        rom_addr_d   = rom_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        if (gnt0) begin
            prio_d     = 1'b1;
            rom_addr_d = addr0;
        end else if (gnt1) begin
            prio_d     = 1'b0;
            rom_addr_d = addr1;
        end
        // Stage k holds the tag whose address went out k+1 cycles ago; the last
        // stage lines up with rom_q carrying that address's data.
        tag_vld_d = {tag_vld_q[ROM_LAT-1:0], gnt0 | gnt1};
        tag_id_d  = {tag_id_q[ROM_LAT-1:0], gnt1};
        if (tag_out_vld) begin
            rsp_data_d   = rom_q;
            rsp_valid0_d = !tag_out_id;
            rsp_valid1_d =  tag_out_id;
        end
    end

    // State registers; reset discards in-flight tags and restores priority to requester 0
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            prio_q       <= 1'b0;
            rom_addr_q   <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            prio_q       <= prio_d;
            rom_addr_q   <= rom_addr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data   = rsp_data_q;

endmodule
